// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive MAC.
package gmii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 step (reflected polynomial, LSB of data first).
module crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // NOTE: blocking assignments here are intentional; each loop pass consumes the
  // previous pass's result within the same evaluation, unrolling into XOR logic.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ CRC_POLY;
      else                      crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/gmii_rx_mac.sv
// GMII receive MAC: preamble/SFD strip, FCS strip, CRC-32 and length check, per-frame status.
// Optional macro RX_STATS_EN adds saturating good/bad/drop frame counters.
module gmii_rx_mac
  import gmii_rx_pkg::*;
#(
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518,
  parameter int MAX_PREAMBLE = 7
) (
  input  logic        GTX_CLK,
  input  logic        RESET,
  input  logic [7:0]  RXD,
  input  logic        RX_DV,
  input  logic        RX_ER,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_done,
  output logic        rx_good,
  output logic        crc_err,
  output logic        len_err,
  output logic        phy_err,
`ifdef RX_STATS_EN
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad,
  output logic [31:0] stat_drop,
`endif
  output logic [15:0] frame_len
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);
  localparam logic [7:0]  MAX_PRE = 8'(MAX_PREAMBLE);

  rx_state_e   r_state, w_state_nxt;
  logic        w_pre_start, w_pre_inc, w_sfd, w_data_byte, w_frame_end, w_drop_end;
  logic [7:0]  r_pcnt;
  logic [15:0] r_bcnt;
  logic [31:0] r_crc, w_crc_nxt;
  logic        r_phy_err;
  logic [7:0]  r_dl [4];
  logic        w_crc_bad, w_len_bad, w_emit;

  crc32_d8 u_crc (
    .crc_in  (r_crc),
    .data    (RXD),
    .crc_out (w_crc_nxt)
  );

  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal written below gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pre_start = 1'b0;
    w_pre_inc   = 1'b0;
    w_sfd       = 1'b0;
    w_data_byte = 1'b0;
    w_frame_end = 1'b0;
    w_drop_end  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (RX_DV) begin
          if (RX_ER) begin
            w_state_nxt = DROP;
          end else if (RXD == PREAMBLE_BYTE) begin
            w_state_nxt = PREAMBLE;
            w_pre_start = 1'b1;
          end else if (RXD == SFD_BYTE) begin
            w_state_nxt = DATA;
            w_sfd       = 1'b1;
          end else begin
            w_state_nxt = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!RX_DV) begin
          w_state_nxt = IDLE;
        end else if (RXD == PREAMBLE_BYTE) begin
          if (r_pcnt >= MAX_PRE) w_state_nxt = DROP;
          else                   w_pre_inc   = 1'b1;
        end else if (RXD == SFD_BYTE) begin
          w_state_nxt = DATA;
          w_sfd       = 1'b1;
        end else begin
          w_state_nxt = DROP;
        end
      end
      DATA: begin
        if (RX_DV) begin
          w_data_byte = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_frame_end = 1'b1;
        end
      end
      DROP: begin
        if (!RX_DV) begin
          w_state_nxt = IDLE;
          w_drop_end  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_crc_bad = (r_crc != CRC_RESIDUE);
  assign w_len_bad = (r_bcnt < MIN_LEN) || (r_bcnt > MAX_LEN);
  // The four newest bytes may be FCS, so a byte leaves only once four more follow it.
  assign w_emit    = w_data_byte && (r_bcnt >= 16'd4);

  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) begin
      r_pcnt    <= '0;
      r_bcnt    <= '0;
      r_crc     <= CRC_INIT;
      r_phy_err <= 1'b0;
    end else begin
      if (w_pre_start)    r_pcnt <= 8'd1;
      else if (w_pre_inc) r_pcnt <= r_pcnt + 8'd1;
      if (w_sfd) begin
        r_bcnt    <= '0;
        r_crc     <= CRC_INIT;
        r_phy_err <= 1'b0;
      end else if (w_data_byte) begin
        r_bcnt <= (r_bcnt == 16'hFFFF) ? r_bcnt : r_bcnt + 16'd1;
        r_crc  <= w_crc_nxt;
        if (RX_ER) r_phy_err <= 1'b1;
      end
    end
  end

  // NOTE: the delay-line storage has no reset; r_bcnt tracks its occupancy, so the
  // stale contents are never observable and the array maps to plain flops/SRL.
  always_ff @(posedge GTX_CLK) begin
    if (w_data_byte) begin
      r_dl[0] <= RXD;
      r_dl[1] <= r_dl[0];
      r_dl[2] <= r_dl[1];
      r_dl[3] <= r_dl[2];
    end
  end

  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_done   <= 1'b0;
      rx_good   <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      phy_err   <= 1'b0;
      frame_len <= '0;
    end else begin
      rx_data   <= w_emit ? r_dl[3] : 8'h00;
      rx_valid  <= w_emit;
      rx_sof    <= w_emit && (r_bcnt == 16'd4);
      rx_done   <= w_frame_end;
      rx_good   <= w_frame_end && !w_crc_bad && !w_len_bad && !r_phy_err;
      crc_err   <= w_frame_end && w_crc_bad;
      len_err   <= w_frame_end && w_len_bad;
      phy_err   <= w_frame_end && r_phy_err;
      frame_len <= (w_frame_end && (r_bcnt >= 16'd4)) ? r_bcnt - 16'd4 : 16'd0;
    end
  end

`ifdef RX_STATS_EN
  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) begin
      stat_good <= '0;
      stat_bad  <= '0;
      stat_drop <= '0;
    end else begin
      if (rx_done && rx_good && (stat_good != '1)) stat_good <= stat_good + 32'd1;
      if (rx_done && !rx_good && (stat_bad != '1)) stat_bad  <= stat_bad + 32'd1;
      if (w_drop_end && (stat_drop != '1))         stat_drop <= stat_drop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gmii_rx_mac.sv
// Self-checking bench for gmii_rx_mac: scoreboard of expected payload bytes and frame status.
module tb_gmii_rx_mac;

  typedef struct packed {
    logic        crc;
    logic        len;
    logic        phy;
    logic        good;
    logic [15:0] flen;
  } status_t;

  logic        GTX_CLK = 1'b0;
  logic        RESET   = 1'b0;
  logic [7:0]  RXD     = 8'h00;
  logic        RX_DV   = 1'b0;
  logic        RX_ER   = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_done, rx_good, crc_err, len_err, phy_err;
  logic [15:0] frame_len;
`ifdef RX_STATS_EN
  logic [31:0] stat_good, stat_bad, stat_drop;
`endif

  int checks = 0, errors = 0;
  int n_done = 0, cyc = 0, t_first = 0, t_sof = 0;
  int exp_good = 0, exp_bad = 0, exp_drop = 0;
  bit mon_en = 1'b1;
  logic [8:0] data_q [$];
  status_t    stat_q [$];
  logic [8:0] mon_e;
  status_t    mon_s;
  status_t    last_s;

  gmii_rx_mac dut (
    .GTX_CLK   (GTX_CLK),
    .RESET     (RESET),
    .RXD       (RXD),
    .RX_DV     (RX_DV),
    .RX_ER     (RX_ER),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_done   (rx_done),
    .rx_good   (rx_good),
    .crc_err   (crc_err),
    .len_err   (len_err),
    .phy_err   (phy_err),
`ifdef RX_STATS_EN
    .stat_good (stat_good),
    .stat_bad  (stat_bad),
    .stat_drop (stat_drop),
`endif
    .frame_len (frame_len)
  );

  always #4 GTX_CLK = ~GTX_CLK;
  always @(posedge GTX_CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i])
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ b[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Payload of n bytes followed by its FCS (complemented CRC, least significant byte first).
  task automatic make_frame(input int n, input int seed, output logic [7:0] f[$]);
    logic [31:0] c;
    f = {};
    for (int i = 0; i < n; i++) f.push_back(8'(i * 13 + seed));
    c = ~crc_model(f);
    for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
  endtask

  task automatic expect_frame(input logic [7:0] f[$], input bit phy);
    status_t s;
    int n;
    n = f.size();
    for (int i = 0; i < n - 4; i++) data_q.push_back({(i == 0), f[i]});
    s.crc  = (crc_model(f) != 32'hDEBB20E3);
    s.len  = (n < 64) || (n > 1518);
    s.phy  = phy;
    s.flen = (n >= 4) ? 16'(n - 4) : 16'd0;
    s.good = !s.crc && !s.len && !phy;
    stat_q.push_back(s);
    if (s.good) exp_good++;
    else        exp_bad++;
  endtask

  task automatic send_raw(input logic [7:0] b[$], input int er_at, input int mark_at);
    foreach (b[i]) begin
      @(posedge GTX_CLK); #1;
      RX_DV = 1'b1;
      RXD   = b[i];
      RX_ER = (i == er_at);
      if (i == mark_at) t_first = cyc;
    end
    @(posedge GTX_CLK); #1;
    RX_DV = 1'b0;
    RX_ER = 1'b0;
    RXD   = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int npre, input int er_at);
    logic [7:0] raw[$];
    raw = {};
    repeat (npre) raw.push_back(8'h55);
    raw.push_back(8'hD5);
    foreach (f[i]) raw.push_back(f[i]);
    send_raw(raw, (er_at < 0) ? -1 : er_at + npre + 1, npre + 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (data_q.size() == 0 && stat_q.size() == 0) break;
      @(posedge GTX_CLK);
    end
    repeat (3) @(posedge GTX_CLK);
    check(tag, 32'(data_q.size() + stat_q.size()), 0);
  endtask

  always @(negedge GTX_CLK) begin
    if (mon_en && RESET) begin
      if (rx_valid) begin
        check("data_expected", 32'(data_q.size() > 0), 1);
        if (data_q.size() > 0) begin
          mon_e = data_q.pop_front();
          check("rx_data", rx_data, mon_e[7:0]);
          check("rx_sof", rx_sof, mon_e[8]);
          if (rx_sof) t_sof = cyc;
        end
      end
      if (rx_done) begin
        n_done++;
        last_s = '{crc: crc_err, len: len_err, phy: phy_err, good: rx_good, flen: frame_len};
        check("done_no_data", rx_valid, 0);
        check("done_expected", 32'(stat_q.size() > 0), 1);
        if (stat_q.size() > 0) begin
          mon_s = stat_q.pop_front();
          check("crc_err", crc_err, mon_s.crc);
          check("len_err", len_err, mon_s.len);
          check("phy_err", phy_err, mon_s.phy);
          check("rx_good", rx_good, mon_s.good);
          check("frame_len", frame_len, mon_s.flen);
        end
      end
    end
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] g[$];
    int n0;

    repeat (3) @(posedge GTX_CLK);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_done", rx_done, 0);
    check("rst_data", rx_data, 0);
    check("rst_flen", frame_len, 0);
    RESET = 1'b1;
    repeat (2) @(posedge GTX_CLK);

    make_frame(60, 1, f);
    expect_frame(f, 1'b0);
    send_frame(f, 7, -1);
    drain("drain_good60");
    check("latency", 32'(t_sof - t_first), 5);
    check("good60_flen", last_s.flen, 60);
    check("good60_good", last_s.good, 1);
    check("good60_ndone", 32'(n_done), 1);

    g = f;
    g[10] = g[10] ^ 8'h04;
    expect_frame(g, 1'b0);
    send_frame(g, 7, -1);
    drain("drain_flip");
    check("flip_crc_err", last_s.crc, 1);
    check("flip_len_err", last_s.len, 0);
    check("flip_good", last_s.good, 0);

    make_frame(16, 7, f);
    expect_frame(f, 1'b0);
    send_frame(f, 7, -1);
    drain("drain_short20");
    check("short20_len_err", last_s.len, 1);
    check("short20_flen", last_s.flen, 16);

    make_frame(59, 3, f);
    expect_frame(f, 1'b0);
    send_frame(f, 7, -1);
    drain("drain_len63");

    make_frame(1514, 5, f);
    expect_frame(f, 1'b0);
    send_frame(f, 7, -1);
    drain("drain_len1518");
    check("len1518_good", last_s.good, 1);

    make_frame(1515, 9, f);
    expect_frame(f, 1'b0);
    send_frame(f, 7, -1);
    drain("drain_len1519");
    check("len1519_len_err", last_s.len, 1);

    make_frame(60, 11, f);
    expect_frame(f, 1'b1);
    send_frame(f, 7, 30);
    drain("drain_phy");
    check("phy_phy_err", last_s.phy, 1);
    check("phy_good", last_s.good, 0);

    make_frame(60, 2, f);
    expect_frame(f, 1'b0);
    send_frame(f, 0, -1);
    drain("drain_nopre");

    g = {8'hA1, 8'hB2};
    expect_frame(g, 1'b0);
    send_frame(g, 3, -1);
    drain("drain_tiny");
    check("tiny_flen", last_s.flen, 0);

    n0 = n_done;
    send_raw({8'h55, 8'h55, 8'hAA, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60}, -1, -1);
    make_frame(60, 4, f);
    send_frame(f, 8, -1);
    g = {8'hD5};
    foreach (f[i]) g.push_back(f[i]);
    send_raw(g, 0, -1);
    drain("drain_drops");
    check("drops_no_done", 32'(n_done - n0), 0);

    n0 = n_done;
    make_frame(60, 21, f);
    make_frame(70, 22, g);
    expect_frame(f, 1'b0);
    expect_frame(g, 1'b0);
    send_frame(f, 7, -1);
    send_frame(g, 7, -1);
    drain("drain_b2b");
    check("b2b_ndone", 32'(n_done - n0), 2);
    check("b2b_last_good", last_s.good, 1);

    mon_en = 1'b0;
    make_frame(60, 31, f);
    @(posedge GTX_CLK); #1;
    RX_DV = 1'b1;
    RXD   = 8'hD5;
    for (int i = 0; i < 30; i++) begin
      @(posedge GTX_CLK); #1;
      RXD = f[i];
    end
    #2;
    RESET = 1'b0;
    #1;
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_done", rx_done, 0);
    RX_DV = 1'b0;
    RXD   = 8'h00;
    repeat (2) @(posedge GTX_CLK);
    #1;
    RESET  = 1'b1;
    mon_en = 1'b1;
    n0 = n_done;
    repeat (10) @(posedge GTX_CLK);
    check("midrst_no_done", 32'(n_done - n0), 0);
    exp_good = 0;
    exp_bad  = 0;
    exp_drop = 0;

    make_frame(60, 41, f);
    expect_frame(f, 1'b0);
    send_frame(f, 7, -1);
    drain("drain_after_rst");
    check("after_rst_good", last_s.good, 1);
    make_frame(64, 42, f);
    expect_frame(f, 1'b0);
    send_frame(f, 7, -1);
    make_frame(80, 43, f);
    expect_frame(f, 1'b0);
    send_frame(f, 7, -1);
    make_frame(60, 44, f);
    f[5] = ~f[5];
    expect_frame(f, 1'b0);
    send_frame(f, 7, -1);
    send_raw({8'h55, 8'h55, 8'hAA, 8'h01, 8'h02}, -1, -1);
    exp_drop++;
    drain("drain_stats");
`ifdef RX_STATS_EN
    check("stat_good", stat_good, 32'(exp_good));
    check("stat_bad", stat_bad, 32'(exp_bad));
    check("stat_drop", stat_drop, 32'(exp_drop));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
